// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory
// over readM/inputReady and drives the IF/ID register.
module fetch_stage #(
  parameter int WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] pc_next_out,
  output logic                 valid_out
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  state_t               state, state_nx;
  logic [WORD_SIZE-1:0] pc, pc_nx, pc_inc;
  logic [WORD_SIZE-1:0] tgt, tgt_nx;
  logic [WORD_SIZE-1:0] buf_instr, buf_instr_nx;
  logic [WORD_SIZE-1:0] buf_pcn, buf_pcn_nx;
  logic [WORD_SIZE-1:0] instr_nx, pcn_nx;
  logic                 valid_nx;

  assign pc_inc    = pc + ONE;
  assign i_address = pc;
  // Gated by reset so the request drops the instant reset asserts.
  assign i_readM   = ~reset & (state != HOLD);

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    tgt_nx       = tgt;
    buf_instr_nx = buf_instr;
    buf_pcn_nx   = buf_pcn;
    instr_nx     = instr_out;
    pcn_nx       = pc_next_out;
    valid_nx     = valid_out;
    if (redirect) begin
      instr_nx     = NOP_INSTR;
      pcn_nx       = '0;
      valid_nx     = 1'b0;
      buf_instr_nx = NOP_INSTR;
      buf_pcn_nx   = '0;
      unique case (state)
        FETCH: begin
          if (i_inputReady) begin
            pc_nx = redirect_pc;
          end else begin
            tgt_nx   = redirect_pc;
            state_nx = DRAIN;
          end
        end
        HOLD: begin
          pc_nx    = redirect_pc;
          state_nx = FETCH;
        end
        DRAIN: begin
          if (i_inputReady) begin
            pc_nx    = redirect_pc;
            state_nx = FETCH;
          end else begin
            tgt_nx = redirect_pc;
          end
        end
        default: state_nx = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (i_inputReady) begin
            pc_nx = pc_inc;
            if (stall) begin
              buf_instr_nx = i_data;
              buf_pcn_nx   = pc_inc;
              state_nx     = HOLD;
            end else begin
              instr_nx = i_data;
              pcn_nx   = pc_inc;
              valid_nx = 1'b1;
            end
          end else if (!stall) begin
            instr_nx = NOP_INSTR;
            pcn_nx   = '0;
            valid_nx = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_nx = buf_instr;
            pcn_nx   = buf_pcn;
            valid_nx = 1'b1;
            state_nx = FETCH;
          end
        end
        DRAIN: begin
          // Stale word is dropped; IF/ID stays a bubble.
          if (i_inputReady) begin
            pc_nx    = tgt;
            state_nx = FETCH;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      tgt         <= '0;
      buf_instr   <= NOP_INSTR;
      buf_pcn     <= '0;
      instr_out   <= NOP_INSTR;
      pc_next_out <= '0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      tgt         <= tgt_nx;
      buf_instr   <= buf_instr_nx;
      buf_pcn     <= buf_pcn_nx;
      instr_out   <= instr_nx;
      pc_next_out <= pcn_nx;
      valid_out   <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory, queue-based
// reference model compared every cycle, plus literal pins.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        reset;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_inputReady;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_next_out;
  logic        valid_out;

  int checks = 0;
  int failures = 0;
  int lat;
  int age = 0;
  logic        p_req = 0;
  logic        p_rdy = 0;
  logic [15:0] p_addr = 0;

  logic [15:0] seq [4] = '{16'h6001, 16'h6102, 16'h6203, 16'h6304};

  fetch_stage #(
    .WORD_SIZE(16),
    .RESET_PC (16'h0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_inputReady(i_inputReady),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .pc_next_out (pc_next_out),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h6001;
      16'h0001: return 16'h6102;
      16'h0002: return 16'h6203;
      16'h0003: return 16'h6304;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: ready after `lat` cycles of a continuous request.
  initial begin
    i_inputReady = 1'b0;
    i_data = 16'hDEAD;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && p_req && !p_rdy) begin
        chk("mem_req_kept", 16'(i_readM), 16'h1);
        chk("mem_addr_kept", i_address, p_addr);
      end
      if (i_inputReady) age = 0;
      if (i_readM) begin
        age++;
        i_inputReady = (age >= lat);
      end else begin
        age = 0;
        i_inputReady = 1'b0;
      end
      i_data = i_inputReady ? mem(i_address) : 16'hDEAD;
      p_req  = i_readM;
      p_rdy  = i_inputReady;
      p_addr = i_address;
    end
  end

  // Reference model: pc, pending-delivery queue, drop-on-return flag.
  logic [15:0] m_pc, m_instr, m_pcn, m_tgt;
  logic        m_valid, m_drop;
  logic [31:0] q[$];

  task automatic model_init();
    m_pc = 16'h0000;
    m_instr = NOP;
    m_pcn = 16'h0000;
    m_valid = 1'b0;
    m_drop = 1'b0;
    m_tgt = 16'h0000;
    q.delete();
  endtask

  task automatic model_step();
    if (redirect) begin
      m_instr = NOP;
      m_pcn = 16'h0000;
      m_valid = 1'b0;
      if (q.size() != 0) begin
        q.delete();
        m_pc = redirect_pc;
      end else if (i_inputReady) begin
        m_pc = redirect_pc;
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        m_tgt = redirect_pc;
      end
    end else if (m_drop) begin
      if (i_inputReady) begin
        m_pc = m_tgt;
        m_drop = 1'b0;
      end
    end else if (q.size() != 0) begin
      if (!stall) begin
        {m_instr, m_pcn} = q.pop_front();
        m_valid = 1'b1;
      end
    end else if (i_inputReady) begin
      if (stall) begin
        q.push_back({i_data, m_pc + 16'd1});
      end else begin
        m_instr = i_data;
        m_pcn = m_pc + 16'd1;
        m_valid = 1'b1;
      end
      m_pc = m_pc + 16'd1;
    end else if (!stall) begin
      m_instr = NOP;
      m_pcn = 16'h0000;
      m_valid = 1'b0;
    end
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_init();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("readM", 16'(i_readM),
          16'(!reset && (m_drop || q.size() == 0)));
      chk("address", i_address, m_pc);
      chk("instr", instr_out, m_instr);
      chk("pc_next", pc_next_out, m_pcn);
      chk("valid", 16'(valid_out), 16'(m_valid));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic pin_reset(input string tag);
    chk({tag, "_readM"}, 16'(i_readM), 16'h0);
    chk({tag, "_valid"}, 16'(valid_out), 16'h0);
    chk({tag, "_instr"}, instr_out, NOP);
    chk({tag, "_pcn"}, pc_next_out, 16'h0000);
    chk({tag, "_addr"}, i_address, 16'h0000);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    lat = 1;
    #1 reset = 1'b1;
    cyc(); #3;
    pin_reset("rst");
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); #3;
      chk("seq_instr", instr_out, seq[k]);
      chk("seq_pcn", pc_next_out, 16'(k + 1));
      chk("seq_valid", 16'(valid_out), 16'h1);
    end

    // stall across the return of addr 2
    do_reset();
    cyc();
    cyc(); stall = 1'b1;
    cyc(); #3;
    chk("hold_instr", instr_out, 16'h6102);
    chk("hold_readM", 16'(i_readM), 16'h0);
    cyc(); #3;
    chk("hold_instr2", instr_out, 16'h6102);
    cyc(); stall = 1'b0; #3;
    chk("hold_instr3", instr_out, 16'h6102);
    cyc(); #3;
    chk("unhold_instr", instr_out, 16'h6203);
    chk("unhold_pcn", pc_next_out, 16'h0003);
    cyc(); #3;
    chk("after_hold", instr_out, 16'h6304);

    // 3-cycle memory, then redirect while a request is outstanding
    lat = 3;
    do_reset();
    cyc(); #3;
    chk("lat_valid", 16'(valid_out), 16'h0);
    chk("lat_instr", instr_out, NOP);
    cyc();
    cyc(); redirect = 1'b1; redirect_pc = 16'h0040; #3;
    chk("lat_first", instr_out, 16'h6001);
    cyc(); redirect = 1'b0; #3;
    chk("drain_addr", i_address, 16'h0001);
    chk("drain_readM", 16'(i_readM), 16'h1);
    cyc(); #3;
    chk("drain_addr2", i_address, 16'h0001);
    chk("drain_valid", 16'(valid_out), 16'h0);
    cyc(); #3;
    chk("redir_addr", i_address, 16'h0040);
    cyc();
    cyc();
    cyc(); lat = 1; redirect = 1'b1; redirect_pc = 16'h0010; #3;
    chk("tgt_instr", instr_out, 16'hA5E5);
    chk("tgt_pcn", pc_next_out, 16'h0041);

    // redirect coinciding with inputReady, then redirect in HOLD
    cyc(); redirect = 1'b0; #3;
    chk("same_addr", i_address, 16'h0010);
    chk("same_valid", 16'(valid_out), 16'h0);
    cyc(); stall = 1'b1; #3;
    chk("same_instr", instr_out, 16'hA5B5);
    chk("same_pcn", pc_next_out, 16'h0011);
    cyc(); redirect = 1'b1; redirect_pc = 16'h0020; #3;
    chk("hold2_readM", 16'(i_readM), 16'h0);
    chk("hold2_instr", instr_out, 16'hA5B5);
    cyc(); redirect = 1'b0; stall = 1'b0; #3;
    chk("hredir_valid", 16'(valid_out), 16'h0);
    chk("hredir_addr", i_address, 16'h0020);
    cyc(); redirect = 1'b1; redirect_pc = 16'hFFFF; #3;
    chk("hredir_instr", instr_out, 16'hA585);
    chk("hredir_pcn", pc_next_out, 16'h0021);

    // wrap at 16'hFFFF, then reset in the middle of a drain
    cyc(); redirect = 1'b0; #3;
    chk("wrap_addr0", i_address, 16'hFFFF);
    cyc(); lat = 3; redirect = 1'b1; redirect_pc = 16'h0030; #3;
    chk("wrap_instr", instr_out, 16'h5A5A);
    chk("wrap_pcn", pc_next_out, 16'h0000);
    chk("wrap_addr", i_address, 16'h0000);
    cyc(); redirect = 1'b0; #3;
    chk("d2_readM", 16'(i_readM), 16'h1);
    chk("d2_valid", 16'(valid_out), 16'h0);
    cyc(); reset = 1'b1; #3;
    pin_reset("midrst");
    cyc(); reset = 1'b0; lat = 1;
    cyc(); #3;
    chk("rerun_instr", instr_out, 16'h6001);
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
